// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an asynchronous PWM/servo
// input in prescaled ticks, with signal-loss detection.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   pwm_in     in   asynchronous pulse input
//   width      out  high time of last complete period (ticks)
//   period     out  rising-to-rising time of last complete period (ticks)
//   valid      out  one-cycle strobe, width/period updated in this cycle
//   timeout    out  level, no complete period within TIMEOUT ticks
//   duty_pct   out  floor(width*100/period) clamped to 100 (optional)
//   duty_valid out  strobe 8 clk after valid (optional)
//
// Build option: define PWM_CAPTURE_DUTY_EN to add the duty-cycle divider
// and the duty_pct/duty_valid outputs.
module pwm_capture #(
    parameter int TICK_DIV = 50,
    parameter int CNT_W    = 16,
    parameter int TIMEOUT  = 40000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] width,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             timeout
`ifdef PWM_CAPTURE_DUTY_EN
    ,
    output logic [6:0]       duty_pct,
    output logic             duty_valid
`endif
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
    localparam logic [31:0] TO_LIM = TIMEOUT;

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t state, state_n;

    logic s1, s2, s3;
    logic [2:0] warm;
    logic rise, fall;

    logic [PW-1:0] pre;
    logic tick;

    logic [CNT_W-1:0] width_cnt, period_cnt, width_hold;
    logic to_hit;

    logic do_start, do_fall, do_meas, do_to, inc_w, inc_p;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Synchronizer plus a warm-up shift so that the reset value of the
    // flops is never mistaken for an edge when the pin is already high.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            warm <= '0;
        end else begin
            s1   <= pwm_in;
            s2   <= s1;
            s3   <= s2;
            warm <= {warm[1:0], 1'b1};
        end
    end

    assign rise = warm[2] & s2 & ~s3;
    assign fall = warm[2] & ~s2 & s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            pre  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (pre == LAST);
            pre  <= (pre == LAST) ? '0 : pre + 1'b1;
        end
    end

    assign to_hit = 32'(period_cnt) >= TO_LIM;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (rise) state_n = HIGH;
            HIGH: begin
                if (fall)        state_n = LOW;
                else if (to_hit) state_n = IDLE;
            end
            LOW: begin
                if (rise)        state_n = HIGH;
                else if (to_hit) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Action decode; an edge always takes precedence over a tick.
    always_comb begin
        do_start = 1'b0;
        do_fall  = 1'b0;
        do_meas  = 1'b0;
        do_to    = 1'b0;
        inc_w    = 1'b0;
        inc_p    = 1'b0;
        unique case (state)
            IDLE: do_start = rise;
            HIGH: begin
                if (fall)        do_fall = 1'b1;
                else if (to_hit) do_to   = 1'b1;
                else if (tick) begin
                    inc_w = 1'b1;
                    inc_p = 1'b1;
                end
            end
            LOW: begin
                if (rise)        do_meas = 1'b1;
                else if (to_hit) do_to   = 1'b1;
                else if (tick)   inc_p   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            width_cnt  <= '0;
            period_cnt <= '0;
            width_hold <= '0;
            width      <= '0;
            period     <= '0;
            valid      <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (do_start || do_meas) begin
                width_cnt  <= '0;
                period_cnt <= '0;
            end else begin
                if (inc_w) width_cnt  <= sat_inc(width_cnt);
                if (inc_p) period_cnt <= sat_inc(period_cnt);
            end
            if (do_fall) width_hold <= width_cnt;
            if (do_meas) begin
                width   <= width_hold;
                period  <= period_cnt;
                valid   <= 1'b1;
                timeout <= 1'b0;
            end
            if (do_to) timeout <= 1'b1;
        end
    end

`ifdef PWM_CAPTURE_DUTY_EN
    localparam int NW = CNT_W + 7;

    logic [NW-1:0] rem, dsr;
    logic [6:0]    quo;
    logic [6:0]    dfv;
    logic [2:0]    dcnt;
    logic          dbusy, dforce;

    // Restoring division with the divisor pre-shifted by 6: the quotient
    // is known to be below 100 once width < period, so 7 bits suffice.
    // Zero period and width >= period bypass the loop with a forced result.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem        <= '0;
            dsr        <= '0;
            quo        <= '0;
            dfv        <= '0;
            dcnt       <= '0;
            dbusy      <= 1'b0;
            dforce     <= 1'b0;
            duty_pct   <= '0;
            duty_valid <= 1'b0;
        end else begin
            duty_valid <= 1'b0;
            if (do_meas) begin
                rem    <= NW'(width_hold) * NW'(100);
                dsr    <= NW'(period_cnt) << 6;
                quo    <= '0;
                dcnt   <= 3'd7;
                dbusy  <= 1'b1;
                dforce <= (period_cnt == '0) || (width_hold >= period_cnt);
                dfv    <= (period_cnt == '0) ? 7'd0 : 7'd100;
            end else if (dbusy) begin
                if (dcnt != 3'd0) begin
                    if (rem >= dsr) rem <= rem - dsr;
                    quo  <= {quo[5:0], rem >= dsr};
                    dsr  <= dsr >> 1;
                    dcnt <= dcnt - 3'd1;
                end else begin
                    dbusy      <= 1'b0;
                    duty_valid <= 1'b1;
                    duty_pct   <= dforce ? dfv : quo;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: scoreboard bench for pwm_capture, one scaled instance
// and one narrow saturating instance.
module tb_pwm_capture;

    localparam int TD = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rst_d;
    logic pin_a, pin_b;
    logic [15:0] w_a, p_a;
    logic v_a, to_a;
    logic [7:0] w_b, p_b;
    logic v_b, to_b;
`ifdef PWM_CAPTURE_DUTY_EN
    logic [6:0] d_a, d_b;
    logic dv_a, dv_b;
`endif

    pwm_capture #(.TICK_DIV(TD), .CNT_W(16), .TIMEOUT(1000)) dut_a (
        .clk(clk), .rst(rst), .pwm_in(pin_a),
        .width(w_a), .period(p_a), .valid(v_a), .timeout(to_a)
`ifdef PWM_CAPTURE_DUTY_EN
        , .duty_pct(d_a), .duty_valid(dv_a)
`endif
    );

    pwm_capture #(.TICK_DIV(8), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .pwm_in(pin_b),
        .width(w_b), .period(p_b), .valid(v_b), .timeout(to_b)
`ifdef PWM_CAPTURE_DUTY_EN
        , .duty_pct(d_b), .duty_valid(dv_b)
`endif
    );

    typedef struct {int w; int p; int tol;} exp_t;
    exp_t qa[$];
    exp_t qb[$];
    int dqa[$];
    int dqb[$];
    int errors = 0;
    int checks = 0;
    int stray  = 0;
    int unsigned since_rst = 0;

    always @(posedge clk) begin
        rst_d <= rst;
        since_rst <= rst ? 0 : since_rst + 1;
    end

    task automatic chk(input string name, input int act,
                       input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_a(input int hi, input int lo);
        pin_a = 1'b1;
        wait_clk(hi * TD);
        pin_a = 1'b0;
        wait_clk(lo * TD);
    endtask

    task automatic expect_a(input int w, input int p, input int tol,
                            input int duty);
        qa.push_back('{w, p, tol});
        dqa.push_back(duty);
    endtask

    task automatic monitor();
        exp_t e;
        int d;
        int sa = 100;
        int sb = 100;
        logic [15:0] pwa = w_a;
        logic [15:0] ppa = p_a;
        forever begin
            @(negedge clk);
            if (v_a) begin
                if (qa.size() == 0) begin
                    chk("a.unexpected_valid", 1, 0, 0);
                end else begin
                    e = qa.pop_front();
                    chk("a.width", int'(w_a), e.w - e.tol, e.w + e.tol);
                    chk("a.period", int'(p_a), e.p - e.tol, e.p + e.tol);
                end
            end
            if (!v_a && !rst_d && (w_a != pwa || p_a != ppa)) stray++;
            pwa = w_a;
            ppa = p_a;
            if (v_b) begin
                if (qb.size() == 0) begin
                    chk("b.unexpected_valid", 1, 0, 0);
                end else begin
                    e = qb.pop_front();
                    chk("b.width", int'(w_b), e.w - e.tol, e.w + e.tol);
                    chk("b.period", int'(p_b), e.p - e.tol, e.p + e.tol);
                end
            end
            sa = v_a ? 0 : sa + 1;
            sb = v_b ? 0 : sb + 1;
`ifdef PWM_CAPTURE_DUTY_EN
            if (dv_a) begin
                chk("a.duty_latency", sa, 8, 8);
                if (dqa.size() == 0) begin
                    chk("a.unexpected_duty_valid", 1, 0, 0);
                end else begin
                    d = dqa.pop_front();
                    chk("a.duty_pct", int'(d_a), d, d);
                end
            end
            if (dv_b) begin
                chk("b.duty_latency", sb, 8, 8);
                if (dqb.size() == 0) begin
                    chk("b.unexpected_duty_valid", 1, 0, 0);
                end else begin
                    d = dqb.pop_front();
                    chk("b.duty_pct", int'(d_b), d, d);
                end
            end
`endif
            if (sa > 1000000) sa = 1000;
            if (sb > 1000000) sb = 1000;
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        pin_a = 1'b0;
        pin_b = 1'b0;
        wait_clk(4);
        chk("rst.a.width", int'(w_a), 0, 0);
        chk("rst.a.period", int'(p_a), 0, 0);
        chk("rst.a.valid", int'(v_a), 0, 0);
        chk("rst.a.timeout", int'(to_a), 0, 0);
        chk("rst.b.width", int'(w_b), 0, 0);
        chk("rst.b.valid", int'(v_b), 0, 0);
        rst = 1'b0;
        fork
            monitor();
        join_none

        // Narrow instance: both counts saturate at 255.
        wait_clk(20);
        pin_b = 1'b1; wait_clk(5000);
        pin_b = 1'b0; wait_clk(1000);
        qb.push_back('{255, 255, 0}); dqb.push_back(100);
        pin_b = 1'b1; wait_clk(5000);
        pin_b = 1'b0; wait_clk(1000);
        qb.push_back('{255, 255, 0}); dqb.push_back(100);
        pin_b = 1'b1; wait_clk(5000);
        pin_b = 1'b0; wait_clk(100);
        chk("b.timeout", int'(to_b), 0, 0);

        // Three periods of 30/400 ticks: first rise gives nothing.
        pulse_a(30, 370);
        expect_a(30, 400, 1, 7); pulse_a(30, 370);
        expect_a(30, 400, 1, 7); pulse_a(30, 370);
        expect_a(30, 400, 1, 7);

        // Then hold low: timeout near 1000 ticks after the last rise.
        pin_a = 1'b1; wait_clk(30 * TD);
        pin_a = 1'b0; wait_clk(920 * TD);
        chk("a.timeout_early", int'(to_a), 0, 0);
        wait_clk(100 * TD);
        chk("a.timeout_set", int'(to_a), 1, 1);
        chk("a.width_hold", int'(w_a), 29, 31);
        chk("a.period_hold", int'(p_a), 399, 401);
        wait_clk(75 * TD);

        // Recovery: two rises, valid on the second.
        pulse_a(30, 370);
        expect_a(30, 400, 1, 7);
        pin_a = 1'b1; wait_clk(12 * TD);
        chk("a.timeout_clear", int'(to_a), 0, 0);

        // Reset in the middle of a HIGH phase.
        rst = 1'b1; wait_clk(2);
        chk("rst2.width", int'(w_a), 0, 0);
        chk("rst2.period", int'(p_a), 0, 0);
        chk("rst2.timeout", int'(to_a), 0, 0);
        chk("rst2.valid", int'(v_a), 0, 0);
        rst = 1'b0;
        wait_clk(18 * TD);
        pin_a = 1'b0; wait_clk(370 * TD);
        pulse_a(30, 370);
        expect_a(30, 400, 1, 7);
        pin_a = 1'b1; wait_clk(30 * TD);
        pin_a = 1'b0; wait_clk(20 * TD);

        // Zero-length period: edges placed between ticks.
        rst = 1'b1; wait_clk(2);
        rst = 1'b0;
        n = 0;
        while ((since_rst < 24 || since_rst % TD != 0) && n < 64) begin
            wait_clk(1);
            n++;
        end
        chk("a.align", n, 0, 63);
        pin_a = 1'b1; wait_clk(2);
        pin_a = 1'b0; wait_clk(2);
        expect_a(0, 0, 0, 0);
        pin_a = 1'b1;

        // Constant high afterwards: timeout, no further duty result.
        wait_clk(1050 * TD);
        chk("a.timeout_high", int'(to_a), 1, 1);
        wait_clk(50);

        chk("a.pending_valid", qa.size(), 0, 0);
        chk("b.pending_valid", qb.size(), 0, 0);
`ifdef PWM_CAPTURE_DUTY_EN
        chk("a.pending_duty", dqa.size(), 0, 0);
        chk("b.pending_duty", dqb.size(), 0, 0);
`endif
        chk("a.stray_update", stray, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter TICK_DIV, default 50, sets clk cycles per measurement tick; legal range 8 or more (50 gives 1 us at 50 MHz).
REQ-002 Parameter CNT_W, default 16, sets the width of the width/period counters and outputs.
REQ-003 Parameter TIMEOUT, default 40000, is the tick count without a completed period that declares signal loss; legal range below 2^CNT_W-1.
REQ-004 clk  input  1  sole clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 pwm_in  input  1  asynchronous PWM/servo pulse input.
REQ-007 width  output  CNT_W  high time of last complete period, in ticks.
REQ-008 period  output  CNT_W  rising-to-rising time of last complete period, in ticks.
REQ-009 valid  output  1  one-cycle strobe; width/period updated in the same cycle.
REQ-010 timeout  output  1  level; signal lost (no complete period within TIMEOUT ticks).

Function
REQ-011 pwm_in shall pass a 2-flop synchronizer; edges are detected on the synchronized copy, giving 3 clk latency from pin edge to internal edge pulse.
REQ-012 Prescaler: free-running 0..TICK_DIV-1, tick pulse for one clk on each wrap to 0.
REQ-013 FSM states: IDLE, HIGH, LOW; reset and timeout enter IDLE.
REQ-014 IDLE: rising edge -> clear width_cnt and period_cnt, enter HIGH; valid is not asserted.
REQ-015 HIGH: each tick increments width_cnt and period_cnt; falling edge -> latch width_cnt into width_hold, enter LOW.
REQ-016 LOW: each tick increments period_cnt; rising edge -> width<=width_hold, period<=period_cnt, valid=1 for one cycle, timeout<=0, clear both counters, enter HIGH.
REQ-017 Edge and tick in the same cycle: the edge action wins; the counters load 0 and that tick is discarded.
REQ-018 Counters saturate at 2^CNT_W-1 and do not wrap.
REQ-019 In HIGH or LOW, period_cnt reaching TIMEOUT with no edge in that cycle -> timeout<=1, enter IDLE; width/period hold their last values.
REQ-020 A constant-high or constant-low input shall therefore raise timeout TIMEOUT ticks after the last rising edge.
REQ-021 width and period change only in the valid cycle, or at reset.

Reset
REQ-022 rst shall set: width=0, period=0, valid=0, timeout=0, state IDLE, prescaler 0, counters 0, synchronizer flops 0, and (if compiled) duty_pct=0, duty_valid=0, divider idle.
REQ-023 rst asserted mid-measurement shall abort the measurement; the first rising edge after release shall not produce valid.

Configuration
REQ-024 Macro PWM_CAPTURE_DUTY_EN defined: adds outputs duty_pct (7 bits) and duty_valid (1 bit).
REQ-025 With the macro, each valid starts a sequential restoring divider: duty_pct = floor(width*100/period), clamped to 100.
  - One quotient bit per clk, 7 iterations.
  - duty_valid pulses exactly 8 clk after valid; duty_pct updates in that cycle.
REQ-026 period = 0 shall yield duty_pct = 0.
REQ-027 A valid arriving while the divider is busy shall restart the divider with the new operands.
REQ-028 Macro undefined: duty_pct, duty_valid and the divider are absent; all other behaviour is unchanged.

Verification
REQ-029 Defaults, 50 MHz clk; 1.5 ms high / 20 ms period, three periods -> no valid on the first rising edge; each later rising edge gives valid, width=1500 +/-1, period=20000 +/-1.
REQ-030 pwm_in held low for 45 ms after a valid period -> timeout=1 about 40 ms after the last rising edge; width/period unchanged; the next two rising edges clear timeout with valid on the second.
REQ-031 rst pulse 5 ms into a HIGH phase -> all outputs 0; the next rising edge gives no valid; the following one gives correct values.
REQ-032 TICK_DIV=8, CNT_W=8, 5000 clk high / 6000 clk period -> width=255, period=255 (saturated), no wrap.
REQ-033 PWM_CAPTURE_DUTY_EN, width=1500, period=20000 -> duty_pct=7, duty_valid exactly 8 clk after valid.
REQ-034 PWM_CAPTURE_DUTY_EN, 100% high input -> timeout asserted, no duty_valid.
REQ-035 PWM_CAPTURE_DUTY_EN, period=0 -> duty_pct=0.
